// File: rtl/alu_ctrl_sequencer_if.sv
// Handshake and decode bundle between instruction decode and the ALU-control sequencer.
interface alu_ctrl_sequencer_if #(
    parameter int CTRL_W = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [5:0]        i_opcode;
    logic [5:0]        i_funct;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_alu_control;
    logic              o_shift_var;
    logic              o_imm_zext;
    logic              o_md_busy;
    logic              o_illegal;

    modport slave (
        input  i_valid, i_opcode, i_funct, i_ready,
        output o_ready, o_valid, o_alu_control, o_shift_var, o_imm_zext, o_md_busy, o_illegal
    );

    modport master (
        output i_valid, i_opcode, i_funct, i_ready,
        input  o_ready, o_valid, o_alu_control, o_shift_var, o_imm_zext, o_md_busy, o_illegal
    );
endinterface

// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU-control decoder with valid/ready handshake and a mul/div stall sequencer.
// Optional macro ALU_ILLEGAL_FLAG_EN enables the registered o_illegal flag (tied 0 otherwise).
module alu_ctrl_sequencer #(
    parameter int CTRL_W     = 5,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    alu_ctrl_sequencer_if.slave  bus
);
    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CTRL_W-1:0] NOP = {CTRL_W{1'b1}};
`ifdef ALU_ILLEGAL_FLAG_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    typedef enum logic [0:0] {IDLE = 1'b0, MD_RUN = 1'b1} state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] code;
        logic              shift_var;
        logic              imm_zext;
        logic              illegal;
        logic              is_mul;
        logic              is_div;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
        dec_t       d;
        logic [4:0] c;
        logic       legal;
        d     = '{code: NOP, default: 1'b0};
        c     = 5'd0;
        legal = 1'b1;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100000: c = 5'd0;
                    6'b100010: c = 5'd1;
                    6'b100100: c = 5'd2;
                    6'b100101: c = 5'd3;
                    6'b101010: c = 5'd4;
                    6'b100110: c = 5'd5;
                    6'b100111: c = 5'd6;
                    6'b000000: c = 5'd7;
                    6'b000100: begin c = 5'd7; d.shift_var = 1'b1; end
                    6'b000010: c = 5'd8;
                    6'b000110: begin c = 5'd8; d.shift_var = 1'b1; end
                    6'b000011: c = 5'd9;
                    6'b000111: begin c = 5'd9; d.shift_var = 1'b1; end
                    6'b101011: c = 5'd10;
                    6'b001000: c = 5'd11;
                    6'b011000: begin c = 5'd16; d.is_mul = 1'b1; end
                    6'b011001: begin c = 5'd17; d.is_mul = 1'b1; end
                    6'b011010: begin c = 5'd18; d.is_div = 1'b1; end
                    6'b011011: begin c = 5'd19; d.is_div = 1'b1; end
                    6'b010000: c = 5'd20;
                    6'b010010: c = 5'd21;
                    default:   legal = 1'b0;
                endcase
            end
            6'b100011, 6'b101011, 6'b001000: c = 5'd0;
            6'b000100, 6'b000101:            c = 5'd1;
            6'b001010:                       c = 5'd4;
            6'b001100: begin c = 5'd2;  d.imm_zext = 1'b1; end
            6'b001101: begin c = 5'd3;  d.imm_zext = 1'b1; end
            6'b001110: begin c = 5'd5;  d.imm_zext = 1'b1; end
            6'b001111: begin c = 5'd15; d.imm_zext = 1'b1; end
            6'b001011:                       c = 5'd12;
            6'b000010:                       c = 5'd11;
            6'b000011:                       c = 5'd13;
            default:                         legal = 1'b0;
        endcase
        // Unknown encodings must not leak partial flags into the output register.
        if (legal) begin
            d.code = CTRL_W'(c);
        end else begin
            d = '{code: NOP, illegal: 1'b1, default: 1'b0};
        end
        return d;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic [CTRL_W-1:0] code_r;
    logic              shift_var_r, imm_zext_r, illegal_r;
    dec_t              dec_s;
    logic              ready_s, accept_s, drain_s, load_s, md_multi_s;
    int                md_n_s;

    // Decode, handshake and next-state logic for the sequencer.
    always_comb begin
        dec_s       = decode(bus.i_opcode, bus.i_funct);
        ready_s     = (state_r == IDLE) && (!valid_r || bus.i_ready);
        accept_s    = bus.i_valid && ready_s;
        drain_s     = valid_r && bus.i_ready;
        md_n_s      = dec_s.is_mul ? MUL_CYCLES : DIV_CYCLES;
        md_multi_s  = (dec_s.is_mul || dec_s.is_div) && (md_n_s > 1);
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        valid_nxt_s = valid_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                    if (md_multi_s) begin
                        valid_nxt_s = 1'b0;
                        cnt_nxt_s   = CNT_W'(md_n_s - 2);
                        state_nxt_s = MD_RUN;
                    end else begin
                        valid_nxt_s = 1'b1;
                    end
                end else if (drain_s) begin
                    valid_nxt_s = 1'b0;
                end else begin
                    valid_nxt_s = valid_r;
                end
            end
            MD_RUN: begin
                // Counter loaded with N-2 so the result appears N cycles after accept.
                if (cnt_r == {CNT_W{1'b0}}) begin
                    valid_nxt_s = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, counter and output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            valid_r     <= 1'b0;
            code_r      <= NOP;
            shift_var_r <= 1'b0;
            imm_zext_r  <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= valid_nxt_s;
            if (load_s) begin
                code_r      <= dec_s.code;
                shift_var_r <= dec_s.shift_var;
                imm_zext_r  <= dec_s.imm_zext;
                illegal_r   <= dec_s.illegal && ILLEGAL_EN;
            end
        end
    end

    assign bus.o_ready       = ready_s;
    assign bus.o_valid       = valid_r;
    assign bus.o_alu_control = code_r;
    assign bus.o_shift_var   = shift_var_r;
    assign bus.o_imm_zext    = imm_zext_r;
    assign bus.o_illegal     = illegal_r;
    assign bus.o_md_busy     = (state_r == MD_RUN);
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Self-checking bench for alu_ctrl_sequencer: directed steps plus random ops against a table model.
module tb_alu_ctrl_sequencer;
    localparam int CTRL_W = 5;
    localparam int MUL_N  = 4;
    localparam int DIV_N  = 32;
    localparam logic [CTRL_W-1:0] NOP = {CTRL_W{1'b1}};
`ifdef ALU_ILLEGAL_FLAG_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   r_tab[int];
    int   i_tab[int];

    always #5 clk = ~clk;

    alu_ctrl_sequencer_if #(.CTRL_W(CTRL_W)) bus();

    alu_ctrl_sequencer #(
        .CTRL_W(CTRL_W), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_known(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return r_tab.exists(int'(fn)) != 0;
        return i_tab.exists(int'(op)) != 0;
    endfunction

    function automatic int ref_code(input logic [5:0] op, input logic [5:0] fn);
        if (!ref_known(op, fn)) return int'(NOP);
        if (op == 6'd0) return r_tab[int'(fn)];
        return i_tab[int'(op)];
    endfunction

    function automatic int ref_lat(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0 && (fn == 6'd24 || fn == 6'd25)) return MUL_N;
        if (op == 6'd0 && (fn == 6'd26 || fn == 6'd27)) return DIV_N;
        return 1;
    endfunction

    function automatic bit ref_shift(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'd0) && (fn == 6'd4 || fn == 6'd6 || fn == 6'd7);
    endfunction

    function automatic bit ref_zext(input logic [5:0] op);
        return (op >= 6'd12) && (op <= 6'd15);
    endfunction

    // Call at a falling edge with i_ready=1; returns at the falling edge where the result is visible
    // (or after the stall cycles have elapsed).
    task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input int stall, input string tag);
        int n;
        bus.i_opcode = op;
        bus.i_funct  = fn;
        bus.i_valid  = 1'b1;
        #1 chk({tag, ".ready"}, 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        n = 1;
        while (bus.o_valid !== 1'b1 && n < 100) begin
            chk({tag, ".busy"}, 32'(bus.o_md_busy), 32'd1);
            chk({tag, ".ready_md"}, 32'(bus.o_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'(ref_lat(op, fn)));
        chk({tag, ".code"}, 32'(bus.o_alu_control), 32'(ref_code(op, fn)));
        chk({tag, ".shift_var"}, 32'(bus.o_shift_var), 32'(ref_shift(op, fn)));
        chk({tag, ".imm_zext"}, 32'(bus.o_imm_zext), 32'(ref_known(op, fn) && ref_zext(op)));
        chk({tag, ".illegal"}, 32'(bus.o_illegal), 32'(ILL_EN && !ref_known(op, fn)));
        chk({tag, ".busy_done"}, 32'(bus.o_md_busy), 32'd0);
        if (stall > 0) begin
            bus.i_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk({tag, ".hold_valid"}, 32'(bus.o_valid), 32'd1);
                chk({tag, ".hold_code"}, 32'(bus.o_alu_control), 32'(ref_code(op, fn)));
                chk({tag, ".hold_ready"}, 32'(bus.o_ready), 32'd0);
            end
            bus.i_ready = 1'b1;
        end
    endtask

    initial begin
        bit          seen_valid;
        logic [5:0]  op, fn;
        r_tab[6'b100000] = 0;  r_tab[6'b100010] = 1;  r_tab[6'b100100] = 2;  r_tab[6'b100101] = 3;
        r_tab[6'b101010] = 4;  r_tab[6'b100110] = 5;  r_tab[6'b100111] = 6;  r_tab[6'b000000] = 7;
        r_tab[6'b000100] = 7;  r_tab[6'b000010] = 8;  r_tab[6'b000110] = 8;  r_tab[6'b000011] = 9;
        r_tab[6'b000111] = 9;  r_tab[6'b101011] = 10; r_tab[6'b001000] = 11; r_tab[6'b011000] = 16;
        r_tab[6'b011001] = 17; r_tab[6'b011010] = 18; r_tab[6'b011011] = 19; r_tab[6'b010000] = 20;
        r_tab[6'b010010] = 21;
        i_tab[6'b100011] = 0;  i_tab[6'b101011] = 0;  i_tab[6'b000100] = 1;  i_tab[6'b000101] = 1;
        i_tab[6'b001000] = 0;  i_tab[6'b001010] = 4;  i_tab[6'b001100] = 2;  i_tab[6'b001101] = 3;
        i_tab[6'b001110] = 5;  i_tab[6'b001011] = 12; i_tab[6'b001111] = 15; i_tab[6'b000010] = 11;
        i_tab[6'b000011] = 13;

        bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_opcode = 6'd0; bus.i_funct = 6'd0;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(bus.o_valid), 32'd0);
        chk("rst.code", 32'(bus.o_alu_control), 32'(NOP));
        chk("rst.busy", 32'(bus.o_md_busy), 32'd0);
        chk("rst.flags", {29'd0, bus.o_shift_var, bus.o_imm_zext, bus.o_illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(6'd0, 6'b100000, 0, "add");
        run_op(6'd0, 6'b000100, 0, "sllv");
        run_op(6'b001000, 6'd5, 0, "addi");
        run_op(6'b001101, 6'd9, 0, "ori");
        run_op(6'b001111, 6'd0, 0, "lui");
        run_op(6'b000011, 6'd0, 0, "jal");
        run_op(6'd0, 6'b011000, 0, "mult");
        run_op(6'd0, 6'b011010, 0, "div");

        // Backpressure: SUB held for 5 cycles, AND waits and is accepted on the draining edge.
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_opcode = 6'd0; bus.i_funct = 6'b100010; bus.i_valid = 1'b1;
        #1 chk("bp.ready_in", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_funct = 6'b100100;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp.valid", 32'(bus.o_valid), 32'd1);
            chk("bp.code", 32'(bus.o_alu_control), 32'd1);
            chk("bp.ready", 32'(bus.o_ready), 32'd0);
        end
        @(negedge clk);
        bus.i_ready = 1'b1;
        #1 chk("bp.ready_rel", 32'(bus.o_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("bp.next_valid", 32'(bus.o_valid), 32'd1);
        chk("bp.next_code", 32'(bus.o_alu_control), 32'd2);
        @(negedge clk);

        // Reset during DIV: no result may appear afterwards.
        bus.i_opcode = 6'd0; bus.i_funct = 6'b011010; bus.i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mdrst.busy_pre", 32'(bus.o_md_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mdrst.valid", 32'(bus.o_valid), 32'd0);
        chk("mdrst.code", 32'(bus.o_alu_control), 32'(NOP));
        chk("mdrst.busy", 32'(bus.o_md_busy), 32'd0);
        chk("mdrst.flags", {29'd0, bus.o_shift_var, bus.o_imm_zext, bus.o_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mdrst.ready", 32'(bus.o_ready), 32'd1);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b0) seen_valid = 1'b1;
        end
        chk("mdrst.no_valid", 32'(seen_valid), 32'd0);
        run_op(6'd0, 6'b100000, 0, "add_post_rst");
        run_op(6'b111111, 6'd0, 1, "illegal_op");

        for (int k = 0; k < 40; k++) begin
            op = 6'($urandom);
            fn = 6'($urandom);
            if ($urandom_range(0, 1) == 0) op = 6'd0;
            if ($urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 50 && !ref_known(op, fn); t++) begin
                    fn = 6'($urandom);
                    op = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
                end
            end
            run_op(op, fn, int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
